// File: rtl/psram_port_arbiter.sv
// Two-port arbiter for the single PSRAM access port.
// Port 0 is the CPU bus and port 1 the DMA side. One transaction is granted
// at a time, the command level is held for HOLD_CYCLES, and both levels are
// kept low for GUARD_CYCLES so the PSRAM sequencer can return to idle.
`timescale 1ns/1ps
module psram_port_arbiter #(
  parameter int HOLD_CYCLES  = 24,
  parameter int GUARD_CYCLES = 4,
  parameter int ROUND_ROBIN  = 1
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        ram_init,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_byte,
  input  logic [21:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_byte,
  input  logic [21:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ram_byte,
  output logic [21:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            grant_valid;
  logic            grant_port;
  logic            cur_port;
  logic            cur_we;
  logic            last_port;
  logic            access_done;
  logic            recover_done;

  assign access_done  = (state == ACCESS)  && (cnt == '0);
  assign recover_done = (state == RECOVER) && (cnt == '0);

  // Arbitration: pick the winner among active requests while calibrated.
  always_comb begin
    grant_valid = ram_init && (p0_req || p1_req);
    if (p0_req && p1_req)
      grant_port = (ROUND_ROBIN != 0) ? ~last_port : 1'b0;
    else
      grant_port = p1_req;
  end

  // State register.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid)  state_next = ACCESS;
      ACCESS:  if (access_done)  state_next = RECOVER;
      RECOVER: if (recover_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command levels derive from state so a reset drops them immediately.
  always_comb begin
    ram_read  = (state == ACCESS) && !cur_we;
    ram_write = (state == ACCESS) &&  cur_we;
    busy      = (state != IDLE);
  end

  // Window counter: HOLD_CYCLES in ACCESS, GUARD_CYCLES in RECOVER.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && grant_valid) begin
      cnt <= CW'(HOLD_CYCLES - 1);
    end else if (access_done) begin
      cnt <= CW'(GUARD_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Latch the winner's command fields on the grant edge; held until next grant.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cur_port  <= 1'b0;
      cur_we    <= 1'b0;
      ram_byte  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (state == IDLE && grant_valid) begin
      cur_port  <= grant_port;
      cur_we    <= grant_port ? p1_we    : p0_we;
      ram_byte  <= grant_port ? p1_byte  : p0_byte;
      ram_addr  <= grant_port ? p1_addr  : p0_addr;
      ram_wdata <= grant_port ? p1_wdata : p0_wdata;
    end
  end

  // Completion: ack pulse, read-data capture and round-robin update.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      last_port <= 1'b1;
    end else begin
      p0_ack <= access_done && !cur_port;
      p1_ack <= access_done &&  cur_port;
      if (access_done) begin
        last_port <= cur_port;
        if (!cur_we) begin
          if (cur_port) p1_rdata <= ram_rdata;
          else          p0_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Testbench for psram_port_arbiter: two instances (default round-robin and a
// short fixed-priority one) share stimulus and are compared every cycle with a
// transaction-level timing model.
`timescale 1ns/1ps
module tb_psram_port_arbiter;

  localparam int A_HOLD = 24;
  localparam int A_GUARD = 4;
  localparam int A_RR = 1;
  localparam int B_HOLD = 2;
  localparam int B_GUARD = 1;
  localparam int B_RR = 0;

  logic        mclk = 1'b0;
  logic        rst;
  logic        ram_init;
  logic        p0_req, p0_we, p0_byte;
  logic [21:0] p0_addr;
  logic [15:0] p0_wdata;
  logic        p1_req, p1_we, p1_byte;
  logic [21:0] p1_addr;
  logic [15:0] p1_wdata;
  logic [15:0] ram_rdata;

  logic        a_p0_ack, a_p1_ack, a_ram_read, a_ram_write, a_ram_byte, a_busy;
  logic [15:0] a_p0_rdata, a_p1_rdata, a_ram_wdata;
  logic [21:0] a_ram_addr;
  logic        b_p0_ack, b_p1_ack, b_ram_read, b_ram_write, b_ram_byte, b_busy;
  logic [15:0] b_p0_rdata, b_p1_rdata, b_ram_wdata;
  logic [21:0] b_ram_addr;

  psram_port_arbiter #(.HOLD_CYCLES(A_HOLD), .GUARD_CYCLES(A_GUARD), .ROUND_ROBIN(A_RR)) dut_a (
    .mclk(mclk), .rst(rst), .ram_init(ram_init),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .ram_read(a_ram_read), .ram_write(a_ram_write), .ram_byte(a_ram_byte),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata), .busy(a_busy)
  );

  psram_port_arbiter #(.HOLD_CYCLES(B_HOLD), .GUARD_CYCLES(B_GUARD), .ROUND_ROBIN(B_RR)) dut_b (
    .mclk(mclk), .rst(rst), .ram_init(ram_init),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .ram_read(b_ram_read), .ram_write(b_ram_write), .ram_byte(b_ram_byte),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata), .busy(b_busy)
  );

  always #5 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: a transaction granted at the edge ending cycle g drives its command
  // in cycles g+1..g+hold, acks in cycle g+hold+1, and the next grant may
  // happen no earlier than the edge ending cycle g+hold+guard+1.
  int          hold [2] = '{A_HOLD, B_HOLD};
  int          guard[2] = '{A_GUARD, B_GUARD};
  bit          rr   [2] = '{A_RR != 0, B_RR != 0};
  int          free_at[2];
  int          gc[2];
  bit          active[2];
  bit          m_port[2], m_we[2], m_byte[2], prefer[2];
  logic [21:0] m_addr[2];
  logic [15:0] m_wdata[2], m_rd0[2], m_rd1[2];
  int          ack_cnt[2][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; gc[i] = 0; active[i] = 0;
      m_port[i] = 0; m_we[i] = 0; m_byte[i] = 0; prefer[i] = 0;
      m_addr[i] = '0; m_wdata[i] = '0; m_rd0[i] = '0; m_rd1[i] = '0;
    end
  endtask

  task automatic clear_acks();
    for (int i = 0; i < 2; i++) begin
      ack_cnt[i][0] = 0;
      ack_cnt[i][1] = 0;
    end
  endtask

  // Apply the effect of the upcoming clock edge using the inputs now driven.
  task automatic model_edge();
    bit p;
    for (int i = 0; i < 2; i++) begin
      if (active[i] && cyc == gc[i] + hold[i]) begin
        if (!m_we[i]) begin
          if (m_port[i]) m_rd1[i] = ram_rdata;
          else           m_rd0[i] = ram_rdata;
        end
        prefer[i] = rr[i] ? !m_port[i] : 1'b0;
      end
      if (cyc >= free_at[i] && ram_init && (p0_req || p1_req)) begin
        p = (p0_req && p1_req) ? prefer[i] : p1_req;
        active[i]  = 1;
        gc[i]      = cyc;
        free_at[i] = cyc + hold[i] + guard[i] + 1;
        m_port[i]  = p;
        m_we[i]    = p ? p1_we    : p0_we;
        m_byte[i]  = p ? p1_byte  : p0_byte;
        m_addr[i]  = p ? p1_addr  : p0_addr;
        m_wdata[i] = p ? p1_wdata : p0_wdata;
      end
    end
  endtask

  task automatic check_outputs();
    logic rd, wr, by, a0, a1, bs, cmd, ack;
    logic [21:0] ad;
    logic [15:0] wd, r0, r1;
    string pfx;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        pfx = "a."; rd = a_ram_read; wr = a_ram_write; by = a_ram_byte; a0 = a_p0_ack; a1 = a_p1_ack;
        bs = a_busy; ad = a_ram_addr; wd = a_ram_wdata; r0 = a_p0_rdata; r1 = a_p1_rdata;
      end else begin
        pfx = "b."; rd = b_ram_read; wr = b_ram_write; by = b_ram_byte; a0 = b_p0_ack; a1 = b_p1_ack;
        bs = b_busy; ad = b_ram_addr; wd = b_ram_wdata; r0 = b_p0_rdata; r1 = b_p1_rdata;
      end
      cmd = !rst && active[i] && cyc >= gc[i] + 1 && cyc <= gc[i] + hold[i];
      ack = !rst && active[i] && cyc == gc[i] + hold[i] + 1;
      check({pfx, "ram_read"},  32'(rd), 32'(cmd && !m_we[i]));
      check({pfx, "ram_write"}, 32'(wr), 32'(cmd && m_we[i]));
      check({pfx, "ram_byte"},  32'(by), 32'(m_byte[i]));
      check({pfx, "ram_addr"},  32'(ad), 32'(m_addr[i]));
      check({pfx, "ram_wdata"}, 32'(wd), 32'(m_wdata[i]));
      check({pfx, "p0_ack"},    32'(a0), 32'(ack && !m_port[i]));
      check({pfx, "p1_ack"},    32'(a1), 32'(ack && m_port[i]));
      check({pfx, "busy"},      32'(bs),
            32'(!rst && active[i] && cyc >= gc[i] + 1 && cyc <= gc[i] + hold[i] + guard[i]));
      check({pfx, "p0_rdata"},  32'(r0), 32'(m_rd0[i]));
      check({pfx, "p1_rdata"},  32'(r1), 32'(m_rd1[i]));
      check({pfx, "rd_wr_excl"}, 32'(rd && wr), 32'(0));
      check({pfx, "ack_excl"},   32'(a0 && a1), 32'(0));
      if (a0) ack_cnt[i][0]++;
      if (a1) ack_cnt[i][1]++;
    end
  endtask

  // One clock: model the edge, let it happen, then check at the falling edge.
  task automatic tick();
    if (!rst) model_edge();
    @(posedge mclk);
    cyc++;
    @(negedge mclk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst.a_ram_read", 32'(a_ram_read), 32'(0));
    check("rst.a_busy", 32'(a_busy), 32'(0));
    check_outputs();
    ticks(n);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1; ram_rdata = '0;
    p0_req = 0; p0_we = 0; p0_byte = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_byte = 0; p1_addr = '0; p1_wdata = '0;
    model_reset();
    clear_acks();
    @(negedge mclk);
    check_outputs();
    ticks(2);
    rst = 1'b0;

    // Port 0 word read.
    p0_addr = 22'h000100; ram_rdata = 16'h1234; p0_req = 1;
    ticks(25);
    p0_req = 0;
    ticks(10);
    check("dir.p0_rdata", 32'(a_p0_rdata), 32'h1234);
    check("dir.p0_acks", 32'(ack_cnt[0][0]), 32'(1));

    // Port 1 byte write at the top address.
    clear_acks();
    p1_we = 1; p1_byte = 1; p1_addr = 22'h3FFFFF; p1_wdata = 16'h00AB; ram_rdata = 16'hDEAD;
    p1_req = 1;
    ticks(25);
    p1_req = 0;
    ticks(10);
    check("dir.p1_acks", 32'(ack_cnt[0][1]), 32'(1));
    check("dir.p1_rdata_kept", 32'(a_p1_rdata), 32'(0));

    // Both held: alternation on A, port 0 only on B.
    clear_acks();
    p0_we = 0; p1_we = 0; p1_byte = 0; p1_addr = 22'h000200;
    p0_req = 1; p1_req = 1;
    ticks(4 * 29);
    check("dir.rr_p0", 32'(ack_cnt[0][0]), 32'(2));
    check("dir.rr_p1", 32'(ack_cnt[0][1]), 32'(2));
    check("dir.fixed_p1", 32'(ack_cnt[1][1]), 32'(0));

    // Calibration pending: nothing granted.
    clear_acks();
    p1_req = 0; ram_init = 0;
    ticks(100);
    check("dir.noinit_acks", 32'(ack_cnt[0][0] + ack_cnt[0][1]), 32'(0));
    ram_init = 1;
    tick();
    check("dir.init_grant", 32'(a_ram_read), 32'(1));
    p0_req = 0;
    ticks(30);

    // Reset in the middle of a read.
    clear_acks();
    p0_req = 1;
    ticks(11);
    pulse_reset(2);
    check("dir.rst_noack", 32'(ack_cnt[0][0]), 32'(0));
    ticks(30);
    check("dir.after_rst_ack", 32'(ack_cnt[0][0]), 32'(1));
    p0_req = 0;
    ticks(30);

    // Requester address changes during the access.
    p0_addr = 22'h10; p0_req = 1;
    ticks(3);
    p0_addr = 22'h20;
    ticks(10);
    check("dir.addr_latched", 32'(a_ram_addr), 32'h10);
    p0_req = 0;
    ticks(20);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) p0_req = ~p0_req;
      if ($urandom_range(0, 15) == 0) p1_req = ~p1_req;
      if ($urandom_range(0, 7) == 0) begin
        p0_we = 1'($urandom); p0_byte = 1'($urandom);
        p0_addr = 22'($urandom); p0_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        p1_we = 1'($urandom); p1_byte = 1'($urandom);
        p1_addr = 22'($urandom); p1_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 149) == 0) ram_init = ~ram_init;
      ram_rdata = 16'($urandom);
      if ($urandom_range(0, 699) == 0) pulse_reset(2);
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
